// File: rtl/fft_frame_feeder_if.sv
// Streaming link between fft_frame_feeder (master) and fft_analyzer (slave):
// start/status, sample handshake and the returned magnitude bin stream.
interface fft_frame_feeder_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_W     = 6
);
    logic                  fft_start;
    logic                  fft_busy;
    logic                  fft_done;
    logic [DATA_WIDTH-1:0] fft_sample;
    logic                  fft_sample_valid;
    logic                  fft_sample_ready;
    logic [ADDR_W-1:0]     bin_index;
    logic [DATA_WIDTH-1:0] bin_magnitude;
    logic                  magnitude_valid;

    modport master (
        output fft_start, fft_sample, fft_sample_valid,
        input  fft_busy, fft_done, fft_sample_ready, bin_index, bin_magnitude, magnitude_valid
    );

    modport slave (
        input  fft_start, fft_sample, fft_sample_valid,
        output fft_busy, fft_done, fft_sample_ready, bin_index, bin_magnitude, magnitude_valid
    );
endinterface

// File: rtl/fft_frame_feeder.sv
// Captures one frame, streams it to the FFT analyzer, and publishes the returned
// magnitudes into a double-banked spectrum RAM for the host.
module fft_frame_feeder #(
    parameter int unsigned FFT_SIZE       = 64,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  arm,
    input  logic                  continuous,
    input  logic                  clear_status,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic                  in_valid,
    output logic                  in_ready,
    fft_frame_feeder_if.master    fft,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  spectrum_valid,
    output logic [15:0]           frame_count,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout_err
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LastIdx     = ADDR_W'(FFT_SIZE - 1);
    localparam logic [ADDR_W:0]   BinsFull    = (ADDR_W + 1)'(FFT_SIZE);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StCapture, StStart, StFeed, StWaitDone, StPublish
    } state_e;

    state_e state;

    logic [DATA_WIDTH-1:0] frame_buf [FFT_SIZE];
    logic [DATA_WIDTH-1:0] spec_mem  [2*FFT_SIZE];

    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W:0]   bins_received;
    logic [CntW-1:0]   wait_cnt;
    logic              bank_sel;

    logic [ADDR_W-1:0] rd_idx_nxt;
    logic              in_fire;
    logic              bin_wr;
    logic              ov_set;
    logic              to_set;
    logic              unused_busy;

    assign rd_idx_nxt  = rd_idx + 1'b1;
    assign in_fire     = (state == StCapture) && in_valid && in_ready;
    assign bin_wr      = fft.magnitude_valid &&
                         (state == StStart || state == StFeed || state == StWaitDone);
    assign ov_set      = in_valid && !in_ready && continuous && (state != StIdle);
    assign to_set      = enable && (state == StWaitDone) && !fft.fft_done &&
                         (wait_cnt == TimeoutLast);
    assign busy        = (state != StIdle);
    assign unused_busy = fft.fft_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= StIdle;
            in_ready             <= 1'b0;
            fft.fft_start        <= 1'b0;
            fft.fft_sample       <= '0;
            fft.fft_sample_valid <= 1'b0;
            wr_idx               <= '0;
            rd_idx               <= '0;
            bins_received        <= '0;
            wait_cnt             <= '0;
            bank_sel             <= 1'b0;
            spectrum_valid       <= 1'b0;
            frame_count          <= '0;
        end else if (!enable) begin
            state                <= StIdle;
            in_ready             <= 1'b0;
            fft.fft_start        <= 1'b0;
            fft.fft_sample_valid <= 1'b0;
        end else begin
            fft.fft_start <= 1'b0;
            if (bin_wr && bins_received != BinsFull) begin
                bins_received <= bins_received + 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (arm) begin
                        state    <= StCapture;
                        in_ready <= 1'b1;
                        wr_idx   <= '0;
                    end
                end
                StCapture: begin
                    if (in_fire) begin
                        if (wr_idx == LastIdx) begin
                            in_ready      <= 1'b0;
                            fft.fft_start <= 1'b1;
                            wr_idx        <= '0;
                            state         <= StStart;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                StStart: begin
                    // A bin arriving alongside start is the first of the new frame.
                    bins_received        <= {{ADDR_W{1'b0}}, fft.magnitude_valid};
                    rd_idx               <= '0;
                    fft.fft_sample       <= frame_buf[0];
                    fft.fft_sample_valid <= 1'b1;
                    state                <= StFeed;
                end
                StFeed: begin
                    if (fft.fft_sample_ready) begin
                        if (rd_idx == LastIdx) begin
                            fft.fft_sample_valid <= 1'b0;
                            wait_cnt             <= '0;
                            state                <= StWaitDone;
                        end else begin
                            rd_idx         <= rd_idx_nxt;
                            fft.fft_sample <= frame_buf[rd_idx_nxt];
                        end
                    end
                end
                StWaitDone: begin
                    if (fft.fft_done) begin
                        state <= StPublish;
                    end else if (wait_cnt == TimeoutLast) begin
                        state <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StPublish: begin
                    if (bins_received == BinsFull) begin
                        bank_sel       <= ~bank_sel;
                        spectrum_valid <= 1'b1;
                        frame_count    <= frame_count + 16'd1;
                    end
                    if (continuous) begin
                        state    <= StCapture;
                        in_ready <= 1'b1;
                        wr_idx   <= '0;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Sticky status: a set in the same cycle as clear_status wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (clear_status) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (ov_set) overrun <= 1'b1;
            if (to_set) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) frame_buf[wr_idx] <= in_sample;
        if (bin_wr) spec_mem[{bank_sel, fft.bin_index}] <= fft.bin_magnitude;
    end

    // Host reads the bank not being written; a read in the flip cycle sees the old bank.
    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= spec_mem[{~bank_sel, rd_addr}];
    end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed self-checking bench for fft_frame_feeder with an inline analyzer model.
module tb_fft_frame_feeder;
    localparam int TIMEOUT = 16384;

    logic        clk = 1'b0;
    logic        reset, enable, arm, continuous, clear_status;
    logic [15:0] in_sample;
    logic        in_valid, in_ready;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        spectrum_valid, busy, overrun, timeout_err;
    logic [15:0] frame_count;
    logic [15:0] sample_mem [64];

    int n_cmp = 0;
    int n_err = 0;

    fft_frame_feeder_if #(.DATA_WIDTH(16), .ADDR_W(6)) fft_bus ();

    fft_frame_feeder #(
        .FFT_SIZE(64), .DATA_WIDTH(16), .ADDR_W(6), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .arm(arm), .continuous(continuous),
        .clear_status(clear_status), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(in_ready), .fft(fft_bus), .rd_addr(rd_addr), .rd_data(rd_data),
        .spectrum_valid(spectrum_valid), .frame_count(frame_count), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_fft_start"}, fft_bus.fft_start, 0);
        chk({tag, "_fft_sample"}, fft_bus.fft_sample, 0);
        chk({tag, "_fft_valid"}, fft_bus.fft_sample_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_spectrum_valid"}, spectrum_valid, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; arm = 1'b0; continuous = 1'b0; clear_status = 1'b0;
        in_sample = '0; in_valid = 1'b0; rd_addr = '0;
        fft_bus.fft_busy = 1'b0; fft_bus.fft_done = 1'b0; fft_bus.fft_sample_ready = 1'b0;
        fft_bus.bin_index = '0; fft_bus.bin_magnitude = '0; fft_bus.magnitude_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic arm_pulse();
        enable = 1'b1; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("arm_in_ready", in_ready, 1);
        chk("arm_busy", busy, 1);
    endtask

    // Ends on the first negedge in START.
    task automatic capture(input int mult, input bit gaps);
        int acc = 0;
        int cyc = 0;
        while (acc < 64 && cyc < 1000) begin
            in_valid  = gaps ? (cyc % 4 != 3) : 1'b1;
            in_sample = 16'(mult * acc);
            if (in_valid && in_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        chk("capture_accepts", acc, 64);
        chk("capture_ready_drop", in_ready, 0);
    endtask

    // Ends on the first negedge in WAIT_DONE.
    task automatic feed(input int mult, input bit toggle);
        int xfer = 0;
        int cyc = 0;
        int starts = 0;
        bit stalled = 1'b0;
        logic [15:0] held = '0;
        while (xfer < 64 && cyc < 2000) begin
            if (stalled) chk("feed_hold", fft_bus.fft_sample, held);
            if (fft_bus.fft_start) starts++;
            fft_bus.fft_sample_ready = toggle ? ((cyc / 3) % 2 == 0) : 1'b1;
            if (fft_bus.fft_sample_valid && fft_bus.fft_sample_ready) begin
                chk("feed_data", fft_bus.fft_sample, 16'(mult * xfer));
                sample_mem[xfer] = fft_bus.fft_sample;
                xfer++;
            end
            stalled = fft_bus.fft_sample_valid && !fft_bus.fft_sample_ready;
            held    = fft_bus.fft_sample;
            cyc++;
            @(negedge clk);
        end
        fft_bus.fft_sample_ready = 1'b0;
        chk("feed_transfers", xfer, 64);
        chk("start_pulses", starts, 1);
        chk("feed_valid_drop", fft_bus.fft_sample_valid, 0);
        chk("feed_busy", busy, 1);
    endtask

    // Ends on the negedge just after the PUBLISH cycle.
    task automatic send_bins(input int n, input bit echo);
        for (int i = 0; i < n; i++) begin
            fft_bus.bin_index       = 6'(i);
            fft_bus.bin_magnitude   = echo ? sample_mem[i] : 16'(10 * i);
            fft_bus.magnitude_valid = 1'b1;
            @(negedge clk);
        end
        fft_bus.magnitude_valid = 1'b0;
        fft_bus.fft_done = 1'b1;
        @(negedge clk);
        fft_bus.fft_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int waited;

        // Reset values
        do_reset();
        check_reset_outputs("rst");

        // Capture with gaps, stalled feed, full spectrum publish
        arm_pulse();
        capture(1, 1'b1);
        in_valid = 1'b0;
        feed(1, 1'b1);
        send_bins(64, 1'b0);
        chk("pub_spectrum_valid", spectrum_valid, 1);
        chk("pub_frame_count", frame_count, 1);
        chk("pub_busy", busy, 0);
        rd_addr = 6'd5;
        @(negedge clk);
        chk("pub_rd_data5", rd_data, 50);

        // Short bin count: frame discarded
        do_reset();
        arm_pulse();
        capture(1, 1'b0);
        in_valid = 1'b0;
        feed(1, 1'b0);
        send_bins(63, 1'b0);
        chk("short_spectrum_valid", spectrum_valid, 0);
        chk("short_frame_count", frame_count, 0);
        chk("short_busy", busy, 0);

        // Timeout
        do_reset();
        arm_pulse();
        capture(2, 1'b0);
        in_valid = 1'b0;
        feed(2, 1'b0);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("to_before", timeout_err, 0);
        chk("to_busy_before", busy, 1);
        @(negedge clk);
        chk("to_set", timeout_err, 1);
        chk("to_idle", busy, 0);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("to_cleared", timeout_err, 0);

        // Continuous mode, overrun, bank flip timing, reset mid-FEED
        do_reset();
        continuous = 1'b1;
        rd_addr = 6'd3;
        in_valid = 1'b1;
        arm_pulse();
        capture(100, 1'b0);
        feed(100, 1'b1);
        chk("cont_overrun", overrun, 1);
        send_bins(64, 1'b1);
        chk("cont1_spectrum_valid", spectrum_valid, 1);
        chk("cont1_frame_count", frame_count, 1);
        chk("cont1_busy", busy, 1);
        capture(200, 1'b0);
        chk("cont_rd_old", rd_data, 300);
        feed(200, 1'b1);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("cont_set_wins", overrun, 1);
        send_bins(64, 1'b1);
        chk("cont_rd_flip_cycle", rd_data, 300);
        chk("cont2_frame_count", frame_count, 2);
        @(negedge clk);
        chk("cont_rd_new", rd_data, 600);
        waited = 0;
        while (!fft_bus.fft_sample_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("cont3_in_feed", fft_bus.fft_sample_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
- Producer/consumer companion to fft_analyzer. Owns both ends of the analyzer's streaming interface.
- Captures one FFT_SIZE-sample frame from an upstream flux-interval/ADC stream into a local buffer.
- Issues start, streams the frame to the analyzer over its sample_valid/sample_ready handshake, and collects the magnitude_valid bin stream.
- Stores the magnitudes in a double-banked spectrum RAM that the host reads while the next frame is processed.

Parameters:
- FFT_SIZE, 64, samples per frame and bins per spectrum (power of two).
- DATA_WIDTH, 16, sample and magnitude width.
- ADDR_W, 6, log2(FFT_SIZE).
- TIMEOUT_CYCLES, 16384, maximum cycles in WAIT_DONE before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable; low forces IDLE.
- arm  in  1  pulse: capture and process one frame.
- continuous  in  1  re-arm automatically after each frame.
- clear_status  in  1  pulse: clears overrun and timeout_err.
- in_sample  in  DATA_WIDTH  signed upstream sample.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  feeder accepting samples.
- fft_start  out  1  one-cycle start pulse to analyzer.
- fft_busy  in  1  analyzer busy.
- fft_done  in  1  analyzer done.
- fft_sample  out  DATA_WIDTH  sample to analyzer.
- fft_sample_valid  out  1  fft_sample valid.
- fft_sample_ready  in  1  analyzer accepts sample.
- bin_index  in  ADDR_W  index of the magnitude being delivered.
- bin_magnitude  in  DATA_WIDTH  bin magnitude.
- magnitude_valid  in  1  bin_magnitude/bin_index valid.
- rd_addr  in  ADDR_W  host spectrum read address.
- rd_data  out  DATA_WIDTH  published spectrum word.
- spectrum_valid  out  1  a complete spectrum has been published.
- frame_count  out  16  published frames, wraps at 16'hFFFF→0.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: input dropped.
- timeout_err  out  1  sticky: done never arrived.

Behaviour:
- Reset values: all outputs 0; state IDLE; bank select 0; sample/bin counters 0. Buffer and RAM contents are don't-care. Reset mid-frame aborts immediately with the same values.
- States:
  - IDLE. Transition to CAPTURE on arm&&enable. arm in any other state is ignored.
  - CAPTURE. in_ready=1. Write in_sample at wr_idx on in_valid&&in_ready. After write FFT_SIZE-1, deassert in_ready the next cycle and go to START.
  - START. fft_start=1 for exactly one cycle. Clear bin counter. Go to FEED.
  - FEED.
    - fft_sample_valid=1, fft_sample=buf[rd_idx]. Data and valid are held stable until a posedge with fft_sample_valid&&fft_sample_ready.
    - On each transfer, rd_idx++. After transfer FFT_SIZE-1, drop valid the next cycle and go to WAIT_DONE.
  - WAIT_DONE.
    - Count cycles. On fft_done go to PUBLISH.
    - At count==TIMEOUT_CYCLES: set timeout_err, go to IDLE, no publish, continuous does not re-arm.
  - PUBLISH (1 cycle). If bins_received==FFT_SIZE: flip bank, spectrum_valid=1, frame_count++. Otherwise discard the frame silently. Next state is CAPTURE if continuous&&enable, else IDLE.
- Bin capture: in START, FEED and WAIT_DONE, magnitude_valid writes bin_magnitude to write-bank[bin_index] and increments bins_received (saturating at FFT_SIZE). magnitude_valid outside those states is ignored. fft_done and magnitude_valid in the same cycle: the bin is written and counted before the PUBLISH check.
- Read port: rd_data = read-bank[rd_addr], registered, 1-cycle latency. The read bank is the one not being written. It changes only at the PUBLISH bank flip. A read issued in the flip cycle returns the old bank.
- overrun: set when in_valid=1 and in_ready=0 while continuous=1 and state!=IDLE. clear_status clears it; simultaneous set and clear → set wins. The same rule applies to timeout_err.
- enable low in any state: next cycle state=IDLE, fft_sample_valid=0, in_ready=0. RAM, spectrum_valid and frame_count are retained.
- No arithmetic on sample data; samples pass bit-exact.

Test Plan:
1. Reset asserted, then released → all outputs 0, in_ready=0, busy=0.
2. enable=1, arm pulse, ramp 0..63 with in_valid gaps → in_ready high for exactly 64 accepts. One fft_start pulse. 64 transfers 0..63 in order. Under a ready model toggling every 3 cycles, fft_sample is held through stalls.
3. Analyzer model sends magnitude_valid bins i=0..63 with value 10*i, then fft_done → spectrum_valid=1, frame_count=1; rd_addr=5 → rd_data=50 one cycle later; busy=0.
4. Same as 3 but only 63 bins delivered → spectrum_valid stays 0, frame_count=0, state returns to IDLE.
5. fft_done withheld → timeout_err=1 exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE, then IDLE. clear_status → timeout_err=0.
6. continuous=1, in_valid held high through two frames with values 100*i then 200*i; hold rd_addr=3 → overrun=1. rd_data reads 300 until the second PUBLISH, then 600. frame_count=2. Then assert reset mid-FEED → outputs return to reset values the next cycle.
